prbs_pattern_gen: RTL
=====================

// Module: prbs_pattern_gen
// PURPOSE
//   Byte-stream source feeding pattern_detector. On enable, emits a 32-bit sync
//   PATTERN n times (4 bytes each, MSB byte first), then free-running PRBS-15 bytes.
//   Sits directly upstream of the detector: out/n drive its in/n inputs.
//   Used standalone in loopback tests of the PRBS link.
// PARAMETERS
//   PATTERN  32'hAABBCCDD  sync word; must equal the detector's PATTERN
//   SEED     15'h7FFF      PRBS-15 LFSR load value; must be non-zero
// PORTS
//   CLK           input   1  clock, all logic on rising edge
//   RSTn          input   1  asynchronous active-low reset
//   en            input   1  level: 1 = run, 0 = abort and return to IDLE
//   n             input   8  pattern repeat count; sampled on start only
//   out           output  8  data byte (registered)
//   valid         output  1  out carries a generated byte this cycle
//   pattern_done  output  1  1-cycle pulse with the last pattern byte
//   busy          output  1  FSM not in IDLE
// BEHAVIOUR
// - Reset (async): state=IDLE, out=8'h00, valid=0, pattern_done=0, busy=0,
//   lfsr=SEED, byte_idx=0, rep_cnt=0, n_q=0.
// - FSM: IDLE -> PAT -> PRBS. Any state -> IDLE on the clock edge where en=0.
// - IDLE: valid=0, out holds 8'h00. On en=1:
//   - Latch n_q=n.
//   - n!=0: go to PAT.
//   - n==0: go to PRBS.
//   - Latency 1: the first byte appears on the edge that samples en=1.
// - PAT: out=PATTERN[31-8*byte_idx -: 8], valid=1.
//   - byte_idx counts 0..3 and wraps.
//   - rep_cnt increments on byte_idx 3 -> 0.
//   - Last byte is byte_idx==3 && rep_cnt==n_q-1: pattern_done=1 in that cycle;
//     next state is PRBS.
//   - rep_cnt is 8-bit and never wraps in normal operation; n_q=255 gives
//     1020 pattern bytes.
// - PRBS: valid=1 every cycle, out = next 8 LFSR bits.
//   - Polynomial x^15+x^14+1. Per bit: b = s[14]^s[13]; s <= {s[13:0], b}.
//   - 8 bit-steps per cycle, computed combinationally. First bit goes to out[7],
//     eighth to out[0].
//   - The LFSR advances only in PRBS state.
//   - Continues indefinitely while en=1.
// - Abort (en=0 in PAT/PRBS) takes effect on the next edge:
//   - valid=0, out=8'h00, pattern_done=0.
//   - lfsr reloaded with SEED; byte_idx and rep_cnt cleared.
//   - Re-asserting en restarts from PATTERN[31:24], so every run is reproducible.
// - n changes after start have no effect until the next start.
// - busy=1 in PAT and PRBS, registered alongside valid.
// - Reset mid-run: immediate return to reset values; no partial byte is emitted.
// - Simultaneous last-pattern-byte and en=0: abort wins. The pattern byte is still
//   output that cycle with pattern_done=1; the next cycle is IDLE.
// - SEED==0 is illegal; the simulation assertion fires at time 0.
// TESTING
// - n=2, en=1 held:
//   - Bytes AA BB CC DD AA BB CC DD, then PRBS 00 02 ...
//   - pattern_done only on the 8th byte.
//   - Remaining PRBS bytes match a bit-serial reference model for 100 bytes.
// - n=0, en=1: the first valid byte is PRBS 8'h00, then 8'h02; pattern_done never set.
// - n=3, drop en after 5 bytes: valid=0 and out=00 on the next cycle.
//   Re-raise en: AA restarts and the PRBS sequence is identical to the first run.
// - Assert RSTn=0 mid-PRBS: outputs clear asynchronously.
//   After release with en=1, the sequence restarts from AA.
// - n=255: exactly 1020 pattern bytes, pattern_done on byte 1020, no counter wrap.
// - Chain into pattern_detector with the same n=4: the detector flags once.
//   Corrupting a single byte suppresses the flag.

Source files
------------

// File: rtl/prbs_pattern_gen.sv
// -----------------------------------------------------------------------------
// prbs_pattern_gen
//   Byte-stream source for the PRBS link. When enabled it first emits the
//   32-bit sync word PATTERN n times (MSB byte first), then free-running
//   PRBS-15 bytes (x^15 + x^14 + 1, eight bit-steps per clock).
//   Dropping en aborts back to IDLE and reloads the LFSR, so every run is
//   reproducible from the first sync byte.
//
// Ports
//   CLK           in   1  clock, rising edge
//   RSTn          in   1  asynchronous active-low reset
//   en            in   1  1 = run, 0 = abort / stay idle
//   n             in   8  sync-word repeat count, sampled on start
//   out           out  8  data byte (registered)
//   valid         out  1  out carries a generated byte
//   pattern_done  out  1  pulse coincident with the last sync byte
//   busy          out  1  generator is running (registered with valid)
// -----------------------------------------------------------------------------
module prbs_pattern_gen #(
  parameter logic [31:0] PATTERN = 32'hAABBCCDD,
  parameter logic [14:0] SEED    = 15'h7FFF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       en,
  input  logic [7:0] n,
  output logic [7:0] out,
  output logic       valid,
  output logic       pattern_done,
  output logic       busy
);

  // An all-zero LFSR locks up; refuse to build with it.
  if (SEED == 15'd0) begin : g_seed_chk
    $error("prbs_pattern_gen: SEED must be non-zero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAT  = 2'd1,
    S_PRBS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_lfsr;
  logic [14:0] w_lfsr_nxt;
  logic [1:0]  r_byte_idx;
  logic [1:0]  w_byte_idx_nxt;
  logic [7:0]  r_rep_cnt;
  logic [7:0]  w_rep_cnt_nxt;
  logic [7:0]  r_n_q;
  logic [7:0]  w_n_q_nxt;
  logic [7:0]  r_out;
  logic [7:0]  w_out_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_busy;
  logic [22:0] w_prbs;      // {next PRBS byte, LFSR state after 8 steps}
  logic        w_last_pat;

  // Eight serial LFSR steps unrolled into one clock. The first feedback bit
  // lands in bit 7 of the byte, the eighth in bit 0.
  function automatic logic [22:0] prbs_step8(input logic [14:0] s_in);
    logic [14:0] s;
    logic [7:0]  b;
    logic        fb;
    s = s_in;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb       = s[14] ^ s[13];
      b[7 - i] = fb;
      s        = {s[13:0], fb};
    end
    return {b, s};
  endfunction

  // Byte idx of the sync word, idx 0 being the most significant byte.
  function automatic logic [7:0] pat_byte(input logic [1:0] idx);
    logic [4:0] lsb;
    lsb = {~idx, 3'b000};
    return PATTERN[lsb +: 8];
  endfunction

  assign w_prbs     = prbs_step8(r_lfsr);
  assign w_last_pat = (r_byte_idx == 2'd3) && (r_rep_cnt == (r_n_q - 8'd1));

  // Next-state and next-output logic. The registered outputs show the byte
  // chosen on the edge, so the first byte appears on the edge that samples
  // en=1 in IDLE and the last sync byte leaves on the PAT->PRBS edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_lfsr_nxt     = r_lfsr;
    w_byte_idx_nxt = r_byte_idx;
    w_rep_cnt_nxt  = r_rep_cnt;
    w_n_q_nxt      = r_n_q;
    w_out_nxt      = 8'h00;
    w_valid_nxt    = 1'b0;
    w_done_nxt     = 1'b0;

    if (!en) begin
      // Abort from any state: back to a clean start point.
      w_state_nxt    = S_IDLE;
      w_lfsr_nxt     = SEED;
      w_byte_idx_nxt = 2'd0;
      w_rep_cnt_nxt  = 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_n_q_nxt   = n;
          w_valid_nxt = 1'b1;
          if (n != 8'd0) begin
            w_out_nxt      = pat_byte(2'd0);
            w_byte_idx_nxt = 2'd1;
            w_rep_cnt_nxt  = 8'd0;
            w_state_nxt    = S_PAT;
          end else begin
            w_out_nxt   = w_prbs[22:15];
            w_lfsr_nxt  = w_prbs[14:0];
            w_state_nxt = S_PRBS;
          end
        end
        S_PAT: begin
          w_valid_nxt    = 1'b1;
          w_out_nxt      = pat_byte(r_byte_idx);
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_rep_cnt_nxt = r_rep_cnt + 8'd1;
          end
          if (w_last_pat) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_PRBS;
          end
        end
        S_PRBS: begin
          w_valid_nxt = 1'b1;
          w_out_nxt   = w_prbs[22:15];
          w_lfsr_nxt  = w_prbs[14:0];
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_lfsr     <= SEED;
      r_byte_idx <= 2'd0;
      r_rep_cnt  <= 8'd0;
      r_n_q      <= 8'd0;
      r_out      <= 8'h00;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_lfsr     <= w_lfsr_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_n_q      <= w_n_q_nxt;
      r_out      <= w_out_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign out          = r_out;
  assign valid        = r_valid;
  assign pattern_done = r_done;
  assign busy         = r_busy;

endmodule
